// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory plus a BOOT/FETCH1/FETCH2 sequencer
// that assembles one- or two-word instructions and presents them with their start address.
module instr_fetch_unit #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 20,
    parameter int LONG_BIT      = WORD_LENGTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pc_load,
    input  logic [ADDRESS_SPACE-1:0]   pc_in,
    input  logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDRESS_SPACE-1:0]   wr_addr,
    input  logic [WORD_LENGTH-1:0]     wr_data,
    output logic [2*WORD_LENGTH-1:0]   instr_out,
    output logic                       instr_valid,
    output logic [ADDRESS_SPACE-1:0]   instr_pc,
    output logic                       is_long
);

    localparam int DEPTH = 2**ADDRESS_SPACE;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_SPACE-1:0]   pc_q, pc_d;
    logic [ADDRESS_SPACE-1:0]   start_q, start_d;
    logic [WORD_LENGTH-1:0]     upper_q, upper_d;
    logic [2*WORD_LENGTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_SPACE-1:0]   instr_pc_q, instr_pc_d;
    logic                       valid_q, valid_d;
    logic                       long_q, long_d;

    logic [WORD_LENGTH-1:0]     mem [DEPTH];
    logic [WORD_LENGTH-1:0]     rd_word;
    logic [ADDRESS_SPACE-1:0]   pc_inc;
    logic [ADDRESS_SPACE-1:0]   boot_vec;

    // PC is held at zero throughout BOOT, so the single read port also yields the boot vector.
    assign rd_word = mem[pc_q];
    assign pc_inc  = pc_q + ADDRESS_SPACE'(1);

    generate
        if (WORD_LENGTH >= ADDRESS_SPACE) begin : g_bv_trunc
            assign boot_vec = rd_word[ADDRESS_SPACE-1:0];
        end else begin : g_bv_ext
            assign boot_vec = {{(ADDRESS_SPACE-WORD_LENGTH){1'b0}}, rd_word};
        end
    endgenerate

    // Read is combinational from the registered PC, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        start_d    = start_q;
        upper_d    = upper_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        long_d     = long_q;

        if (pc_load) begin
            state_d = FETCH1;
            pc_d    = pc_in;
            upper_d = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                BOOT: begin
                    pc_d    = boot_vec;
                    state_d = FETCH1;
                    valid_d = 1'b0;
                end
                FETCH1: begin
                    pc_d = pc_inc;
                    if (rd_word[LONG_BIT]) begin
                        upper_d = rd_word;
                        start_d = pc_q;
                        valid_d = 1'b0;
                        state_d = FETCH2;
                    end else begin
                        instr_d    = {{WORD_LENGTH{1'b0}}, rd_word};
                        instr_pc_d = pc_q;
                        long_d     = 1'b0;
                        valid_d    = 1'b1;
                    end
                end
                FETCH2: begin
                    instr_d    = {upper_q, rd_word};
                    instr_pc_d = start_q;
                    long_d     = 1'b1;
                    valid_d    = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = FETCH1;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= '0;
            start_q    <= '0;
            upper_q    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            start_q    <= start_d;
            upper_q    <= upper_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            long_q     <= long_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;
    assign is_long     = long_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a word-stream reference model predicts each
// instruction and the edge it should appear on; a negedge monitor checks the DUT against it.
module tb_instr_fetch_unit;

    logic        clk, reset, pc_load, stall, wr_en;
    logic [19:0] pc_in, wr_addr;
    logic [15:0] wr_data;
    logic [31:0] instr_out;
    logic        instr_valid, is_long;
    logic [19:0] instr_pc;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_in(pc_in), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_pc(instr_pc), .is_long(is_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [19:0] pc;
        logic        lng;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0, cyc = 0;
    logic        last_stall = 1'b0, last_load = 1'b0;

    // reference model: memory image and position in the instruction word stream
    logic [15:0] mm [int unsigned];
    bit          booting, partial, pushed_last;
    logic [19:0] ptr, start;
    logic [15:0] upper;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        last_stall <= stall;
        last_load  <= pc_load;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [31:0] ins, input logic [19:0] pc, input logic lng);
        exp_t e;
        e.instr = ins; e.pc = pc; e.lng = lng; e.cyc = cyc + 1;
        q.push_back(e);
        pushed_last = 1'b1;
    endfunction

    // One clock of the stream: each unstalled cycle consumes the next word; an
    // instruction is due once its last word has been consumed.
    function automatic void model_cycle(input logic pcl, input logic [19:0] pci, input logic stl);
        logic [15:0] w;
        pushed_last = 1'b0;
        if (pcl) begin
            ptr = pci; partial = 1'b0; booting = 1'b0;
        end else if (!stl) begin
            if (booting) begin
                ptr = {4'h0, mm[0]};
                booting = 1'b0;
            end else begin
                w = mm[ptr];
                if (partial) begin
                    push({upper, w}, start, 1'b1);
                    partial = 1'b0;
                end else if (w[15]) begin
                    partial = 1'b1; upper = w; start = ptr;
                end else begin
                    push({16'h0, w}, ptr, 1'b0);
                end
                ptr = ptr + 20'd1;
            end
        end
    endfunction

    task automatic step(input logic pcl, input logic [19:0] pci, input logic stl,
                        input logic we, input logic [19:0] wa, input logic [15:0] wd);
        @(negedge clk);
        pc_load = pcl; pc_in = pci; stall = stl; wr_en = we; wr_addr = wa; wr_data = wd;
        model_cycle(pcl, pci, stl);
        if (we) mm[wa] = wd;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 16'h0);
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d);
        step(1'b0, 20'h0, 1'b1, 1'b1, a, d);
    endtask

    task automatic jump(input logic [19:0] a);
        step(1'b1, a, 1'b0, 1'b0, 20'h0, 16'h0);
    endtask

    // Reset raised between edges with a write attempt pending; released with a live first cycle.
    task automatic reset_mid(input logic [19:0] wa);
        @(negedge clk);
        pc_load = 1'b0; stall = 1'b0; wr_en = 1'b1; wr_addr = wa; wr_data = 16'hDEAD;
        #2 reset = 1'b1;
        #1;
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr_pc", {12'h0, instr_pc}, 32'h0);
        chk("rst_is_long", {31'h0, is_long}, 32'h0);
        q.delete();
        booting = 1'b1; partial = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b0; reset = 1'b0;
        model_cycle(1'b0, 20'h0, 1'b0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        w[15] = ($urandom_range(0, 9) < 3);
        return w;
    endfunction

    // monitor
    initial begin
        logic        pv, pl;
        logic [31:0] pi;
        logic [19:0] pp;
        exp_t        e;
        pv = 1'b0; pl = 1'b0; pi = '0; pp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++; errors++;
                    $display("FAIL missing: no valid output for expected %h @%h (edge %0d)", e.instr, e.pc, e.cyc);
                end
                if (instr_valid) begin
                    if (last_stall && !last_load && pv) begin
                        chk("hold_instr", instr_out, pi);
                        chk("hold_pc", {12'h0, instr_pc}, {12'h0, pp});
                        chk("hold_long", {31'h0, is_long}, {31'h0, pl});
                    end else if (q.size() > 0 && q[0].cyc == cyc) begin
                        e = q.pop_front();
                        chk("instr_out", instr_out, e.instr);
                        chk("instr_pc", {12'h0, instr_pc}, {12'h0, e.pc});
                        chk("is_long", {31'h0, is_long}, {31'h0, e.lng});
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected: valid output %h @%h at edge %0d", instr_out, instr_pc, cyc);
                    end
                end
                pv = instr_valid; pi = instr_out; pp = instr_pc; pl = is_long;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pcl, stl, we, force_jmp;
        logic [19:0] pci, wa;
        reset = 1'b1; pc_load = 1'b0; stall = 1'b1; wr_en = 1'b0;
        pc_in = '0; wr_addr = '0; wr_data = '0;
        booting = 1'b1; partial = 1'b0; ptr = '0; start = '0; upper = '0; pushed_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_instr_out", instr_out, 32'h0);
        chk("init_valid", {31'h0, instr_valid}, 32'h0);
        chk("init_instr_pc", {12'h0, instr_pc}, 32'h0);
        chk("init_is_long", {31'h0, is_long}, 32'h0);
        reset = 1'b0;

        // program image, loaded while the unit is stalled in BOOT
        for (int a = 0; a < 256; a++) begin
            logic [15:0] d;
            d = rand_word();
            case (a)
                'h00: d = 16'h0010;
                'h10: d = 16'h1234;
                'h30: d = 16'h8123;
                'h40: d = 16'h0440;
                'h50: d = 16'h0123;
                'h51: d = 16'h8005;
                'h52: d = 16'h0AAA;
                default: ;
            endcase
            wr(20'(a), d);
        end
        for (int a = 'hFFFF0; a <= 'hFFFFF; a++) wr(20'(a), rand_word());

        // boot: vector 0x10 fetched, 0x1234 due on the second edge after release
        reset_mid(20'h10);
        run(6);

        // long instruction at 0x10, next from 0x12
        wr(20'h10, 16'h8001); wr(20'h11, 16'hBEEF); wr(20'h12, 16'h0012);
        jump(20'h10);
        run(5);

        // stall for three cycles while an instruction is valid
        for (int i = 0; i < 4 && !pushed_last; i++) run(1);
        repeat (3) step(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 16'h0);
        run(4);

        // redirect with stall during FETCH2
        jump(20'h30);
        run(1);
        step(1'b1, 20'h40, 1'b1, 1'b0, 20'h0, 16'h0);
        @(posedge clk); #1;
        chk("redirect_valid_low", {31'h0, instr_valid}, 32'h0);
        run(3);

        // wrap at the top of the address space
        wr(20'hFFFFF, 16'h8002); wr(20'h0, 16'h0007);
        jump(20'hFFFFF);
        run(4);

        // async reset mid-FETCH2, then reboot from vector 7 through intact memory
        jump(20'h50);
        run(2);
        reset_mid(20'h9);
        run(10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            force_jmp = (ptr > 20'hF0 && ptr < 20'hFFFF0);
            pcl = force_jmp || ($urandom_range(0, 99) < 8);
            pci = ($urandom_range(0, 9) == 0) ? 20'($urandom_range('hFFFF8, 'hFFFFF))
                                              : 20'($urandom_range(1, 'hE0));
            stl = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 5) == 0 && ptr >= 20'h1 && ptr <= 20'hFF) wa = ptr;
            else wa = 20'($urandom_range(1, 255));
            step(pcl, pci, stl, we, wa, rand_word());
        end
        run(3);
        @(negedge clk); #2;
        chk("queue_drained", q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter WORD_LENGTH, default 16, SHALL set the memory word width in bits.
REQ-002 Parameter ADDRESS_SPACE, default 20, SHALL set the address width; depth SHALL be 2**ADDRESS_SPACE words.
REQ-003 Parameter LONG_BIT, default WORD_LENGTH-1, SHALL be the bit index in the first word that marks a two-word instruction.
REQ-004 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 Port pc_load  input  1  SHALL be a redirect strobe for a branch, jump or interrupt.
REQ-007 Port pc_in  input  ADDRESS_SPACE  SHALL be the redirect target.
REQ-008 Port stall  input  1  SHALL hold the fetch state and outputs.
REQ-009 Port wr_en  input  1  SHALL be the program-load write strobe.
REQ-010 Port wr_addr  input  ADDRESS_SPACE  SHALL be the program-load address.
REQ-011 Port wr_data  input  WORD_LENGTH  SHALL be the program-load data.
REQ-012 Port instr_out  output  2*WORD_LENGTH  SHALL be the assembled instruction as {first word, second word}; short instructions SHALL be {zeros, word}.
REQ-013 Port instr_valid  output  1  SHALL mark instr_out as a complete instruction.
REQ-014 Port instr_pc  output  ADDRESS_SPACE  SHALL be the address of the first word of instr_out.
REQ-015 Port is_long  output  1  SHALL be high when instr_out holds a two-word instruction.

Function
REQ-016 The FSM SHALL have the states BOOT, FETCH1 and FETCH2, plus a PC register of ADDRESS_SPACE bits.
REQ-017 BOOT SHALL last one cycle: PC <= zero-extended mem[0], next state FETCH1, instr_valid 0.
REQ-018 In FETCH1, when word = mem[PC] has bit LONG_BIT clear:
- instr_out <= {0, word}, is_long <= 0, instr_pc <= PC, instr_valid <= 1.
- PC <= PC+1; state stays FETCH1.
REQ-019 In FETCH1, when bit LONG_BIT is set:
- The unit SHALL latch word as the upper half and the start address.
- instr_valid <= 0, PC <= PC+1, next state FETCH2.
REQ-020 In FETCH2, the unit SHALL set:
- instr_out <= {upper, mem[PC]}, is_long <= 1, instr_pc <= latched start address, instr_valid <= 1.
- PC <= PC+1, next state FETCH1.
REQ-021 Latency: a short instruction SHALL be valid 1 cycle after its fetch edge; a long one SHALL be valid 2 cycles after the fetch of its first word.
REQ-022 When stall is high and pc_load is low, the unit SHALL hold the state, PC, latched upper word and all outputs unchanged, including instr_valid.
REQ-023 pc_load SHALL take priority over stall:
- PC <= pc_in, state <= FETCH1, instr_valid <= 0 next cycle.
- Any partial long instruction SHALL be discarded.
REQ-024 pc_load during BOOT SHALL override the boot vector.
REQ-025 PC arithmetic SHALL wrap modulo 2**ADDRESS_SPACE; a long instruction at the top address SHALL take its second word from address 0.
REQ-026 Writes SHALL be synchronous: mem[wr_addr] <= wr_data when wr_en=1 and reset=0.
REQ-027 On a write to the address being read in the same cycle, the read SHALL return the old data.
REQ-028 Writes SHALL proceed regardless of stall and pc_load.

Reset
REQ-029 reset=1 SHALL asynchronously set state=BOOT, PC=0, instr_out=0, instr_valid=0, instr_pc=0, is_long=0 and clear the latched upper word.
REQ-030 Memory contents SHALL NOT be altered by reset; wr_en SHALL be ignored while reset=1.
REQ-031 Assertion of reset mid-FETCH2 SHALL abort the long instruction with no valid output; BOOT SHALL follow deassertion.

Verification
REQ-032 The bench SHALL cover the boot scenario: mem[0]=0x0010, mem[0x10]=0x1234, release reset -> instr_valid=1, instr_out=0x00001234, instr_pc=0x10, is_long=0 on the second rising edge after release.
REQ-033 The bench SHALL cover a long instruction: mem[0x10]=0x8001, mem[0x11]=0xBEEF -> no valid on the 0x10 fetch, then instr_out=0x8001BEEF, instr_pc=0x10, is_long=1; the next instruction comes from 0x12.
REQ-034 The bench SHALL cover stall: stall=1 for 3 cycles while valid -> instr_out, instr_pc and PC remain unchanged; fetch resumes from the same PC after release.
REQ-035 The bench SHALL cover redirect: pc_load=1, pc_in=0x40 with stall=1 during FETCH2 -> the next cycle has instr_valid=0, and the following output is mem[0x40] with instr_pc=0x40.
REQ-036 The bench SHALL cover wrap: pc_in=0xFFFFF, mem[0xFFFFF]=0x8002, mem[0]=0x0007 -> instr_out=0x80020007, instr_pc=0xFFFFF, next fetch from address 1.
REQ-037 The bench SHALL cover async reset mid-operation: reset pulsed between clock edges during FETCH2 -> all outputs 0 immediately, without waiting for a clock edge, and memory contents remain intact after reset.
